// File: rtl/stoch_matrix_mult_acc.sv
// Pipelined unipolar stochastic matrix multiplier Y = A*B: stage 1 popcounts AND-ed bit pairs,
// stage 2 folds each count into one output bit through a per-element remainder accumulator.
module stoch_matrix_mult_acc #(
    parameter int NUM_ROWS  = 2,
    parameter int NUM_MID   = 2,
    parameter int NUM_COLS  = 2,
    parameter int SCALED    = 0,
    parameter int SAT_LIMIT = 2 * NUM_MID
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               CLR,
    input  logic                               in_valid,
    input  logic [NUM_ROWS-1:0][NUM_MID-1:0]   A,
    input  logic [NUM_MID-1:0][NUM_COLS-1:0]   B,
    output logic                               out_valid,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y
);

    localparam int MAXV  = (NUM_MID > SAT_LIMIT) ? NUM_MID : SAT_LIMIT;
    localparam int CNT_W = $clog2(NUM_MID + 1);
    localparam int ACC_W = $clog2(MAXV + 1);
    localparam int S_W   = $clog2(MAXV + NUM_MID + 1);

    localparam logic [S_W-1:0] MID_S = S_W'(NUM_MID);
    localparam logic [S_W-1:0] SAT_S = S_W'(SAT_LIMIT);

    logic [CNT_W-1:0]                  c_nxt   [NUM_ROWS][NUM_COLS];
    logic [CNT_W-1:0]                  c_p1    [NUM_ROWS][NUM_COLS];
    logic                              vld_p1;
    logic [ACC_W-1:0]                  acc_p2  [NUM_ROWS][NUM_COLS];
    logic [ACC_W-1:0]                  acc_nxt [NUM_ROWS][NUM_COLS];
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] y_nxt;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_MID-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < NUM_MID; k++) cnt = cnt + CNT_W'(v[k]);
        return cnt;
    endfunction

    // Unscaled mode consumes one unit per output 1 and drops anything above the ceiling.
    function automatic logic [S_W-1:0] sat_clip(input logic [S_W-1:0] s);
        logic [S_W-1:0] d;
        if (s == '0) return '0;
        d = s - S_W'(1);
        return (d > SAT_S) ? SAT_S : d;
    endfunction

    function automatic logic out_bit(input logic [S_W-1:0] s);
        if (SCALED != 0) return (s >= MID_S);
        return (s != '0);
    endfunction

    function automatic logic [ACC_W-1:0] next_acc(input logic [S_W-1:0] s);
        logic [S_W-1:0] r;
        if (SCALED != 0) r = (s >= MID_S) ? (s - MID_S) : s;
        else             r = sat_clip(s);
        return ACC_W'(r);
    endfunction

    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
            logic [NUM_MID-1:0] prod;
            logic [S_W-1:0]     s;
            for (genvar gk = 0; gk < NUM_MID; gk++) begin : g_mid
                assign prod[gk] = A[gi][gk] & B[gk][gj];
            end
            assign c_nxt[gi][gj]   = popcnt(prod);
            assign s               = S_W'(acc_p2[gi][gj]) + S_W'(c_p1[gi][gj]);
            assign y_nxt[gi][gj]   = out_bit(s);
            assign acc_nxt[gi][gj] = next_acc(s);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            Y         <= '0;
            for (int i = 0; i < NUM_ROWS; i++)
                for (int j = 0; j < NUM_COLS; j++)
                    acc_p2[i][j] <= '0;
        end else begin
            // Stage 1 boundary: counts load even under CLR, so a sample arriving with CLR survives.
            vld_p1 <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < NUM_ROWS; i++)
                    for (int j = 0; j < NUM_COLS; j++)
                        c_p1[i][j] <= c_nxt[i][j];
            end
            // Stage 2 boundary: CLR drops the stage-1 sample and restarts accumulation; Y holds.
            if (CLR) begin
                out_valid <= 1'b0;
                for (int i = 0; i < NUM_ROWS; i++)
                    for (int j = 0; j < NUM_COLS; j++)
                        acc_p2[i][j] <= '0;
            end else begin
                out_valid <= vld_p1;
                if (vld_p1) begin
                    Y <= y_nxt;
                    for (int i = 0; i < NUM_ROWS; i++)
                        for (int j = 0; j < NUM_COLS; j++)
                            acc_p2[i][j] <= acc_nxt[i][j];
                end
            end
        end
    end

endmodule
